// File: rtl/sipo_pkg.sv
// Shared types and helpers for the serial-in, parallel-out shift register.
package sipo_pkg;

  // Holding-register occupancy; the encoding doubles as par_valid.
  typedef enum logic {
    HOLD_EMPTY = 1'b0,
    HOLD_FULL  = 1'b1
  } hold_state_e;

  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/sipo_shift_reg_if.sv
// Bit-stream input, parallel valid/ready output and status for sipo_shift_reg.
interface sipo_shift_reg_if #(
  parameter int WIDTH = 8
);
  import sipo_pkg::*;

  // Handshake: ser_in is taken on any edge with ser_valid high and clear low
  // (no back-pressure); par_out is transferred on any edge with par_valid and
  // par_ready both high, and par_out stays stable until that edge.
  logic             ser_in;
  logic             ser_valid;
  logic             clear;
  logic [WIDTH-1:0] par_out;
  logic             par_valid;
  logic             par_ready;
  logic             busy;
  logic             overrun;
  hold_state_e      hold_state;

  modport master (
    output ser_in, ser_valid, clear, par_ready,
    input  par_out, par_valid, busy, overrun, hold_state
  );

  modport slave (
    input  ser_in, ser_valid, clear, par_ready,
    output par_out, par_valid, busy, overrun, hold_state
  );

endinterface

// File: rtl/sipo_shift_core.sv
// Shift register and bit counter; flags the edge on which a word completes.
module sipo_shift_core
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ser_in,
  input  logic             ser_valid,
  input  logic             clear,
  output logic [WIDTH-1:0] word,
  output logic             word_done,
  output logic             busy
);

  localparam int CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] shifted;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  assign accept = ser_valid & ~clear;

  generate
    if (MSB_FIRST) begin : g_msb
      assign shifted = {sreg[WIDTH-2:0], ser_in};
    end else begin : g_lsb
      assign shifted = {ser_in, sreg[WIDTH-1:1]};
    end
  endgenerate

  // The completed word includes the bit arriving on this edge.
  assign word      = shifted;
  assign word_done = accept && (cnt == LAST);
  assign busy      = (cnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (clear) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (ser_valid) begin
      sreg <= shifted;
      cnt  <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sipo_shift_reg.sv
// Serial-in, parallel-out shift register with a one-deep holding register
// on a valid/ready output port and overrun reporting.
module sipo_shift_reg
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  sipo_shift_reg_if.slave  bus
);

  logic [WIDTH-1:0] word;
  logic             word_done;
  logic             core_busy;
  logic [WIDTH-1:0] hold;
  logic             overrun_q;
  hold_state_e      state;
  logic             pop;

  sipo_shift_core #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .ser_in    (bus.ser_in),
    .ser_valid (bus.ser_valid),
    .clear     (bus.clear),
    .word      (word),
    .word_done (word_done),
    .busy      (core_busy)
  );

  assign pop = (state == HOLD_FULL) && bus.par_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HOLD_EMPTY;
      hold      <= '0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      case (state)
        HOLD_EMPTY: begin
          if (word_done) begin
            hold  <= word;
            state <= HOLD_FULL;
          end
        end
        HOLD_FULL: begin
          // A pop on the completion edge frees the slot just in time.
          if (word_done && pop) begin
            hold <= word;
          end else if (word_done) begin
            overrun_q <= 1'b1;
          end else if (pop) begin
            state <= HOLD_EMPTY;
          end
        end
        default: state <= HOLD_EMPTY;
      endcase
    end
  end

  assign bus.par_out    = hold;
  assign bus.par_valid  = (state == HOLD_FULL);
  assign bus.busy       = core_busy;
  assign bus.overrun    = overrun_q;
  assign bus.hold_state = state;

endmodule

// File: tb/tb_sipo_shift_reg.sv
// Directed bench for sipo_shift_reg: MSB-first and LSB-first instances share stimulus.
module tb_sipo_shift_reg;

  logic clk;
  logic rst_n;
  logic ser_in;
  logic ser_valid;
  logic clear;
  logic par_ready;

  int n_tests = 0;
  int n_fail  = 0;

  sipo_shift_reg_if #(.WIDTH(8)) if_msb ();
  sipo_shift_reg_if #(.WIDTH(8)) if_lsb ();

  assign if_msb.ser_in    = ser_in;
  assign if_msb.ser_valid = ser_valid;
  assign if_msb.clear     = clear;
  assign if_msb.par_ready = par_ready;
  assign if_lsb.ser_in    = ser_in;
  assign if_lsb.ser_valid = ser_valid;
  assign if_lsb.clear     = clear;
  assign if_lsb.par_ready = par_ready;

  sipo_shift_reg #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_msb)
  );

  sipo_shift_reg #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_lsb)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drivers: inputs change just after the falling edge, outputs are read there too.
  task automatic send_bit(input logic b);
    ser_in    = b;
    ser_valid = 1'b1;
    @(negedge clk);
    ser_valid = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic pop_one();
    par_ready = 1'b1;
    @(negedge clk);
    par_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] pat;
    logic [7:0]  w;
    int          gaps[8];
    int          ovr_seen;

    rst_n = 1'b0; ser_in = 1'b0; ser_valid = 1'b0; clear = 1'b0; par_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_par_out",   32'(if_msb.par_out),   32'h0);
    check("rst_par_valid", 32'(if_msb.par_valid), 32'h0);
    check("rst_overrun",   32'(if_msb.overrun),   32'h0);
    check("rst_busy",      32'(if_msb.busy),      32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic word, both bit orders
    par_ready = 1'b1;
    w = 8'hB2;
    for (int i = 7; i >= 1; i--) send_bit(w[i]);
    check("b2_busy_mid",  32'(if_msb.busy),      32'h1);
    check("b2_valid_mid", 32'(if_msb.par_valid), 32'h0);
    send_bit(w[0]);
    check("b2_valid",     32'(if_msb.par_valid), 32'h1);
    check("b2_out",       32'(if_msb.par_out),   32'hB2);
    check("b2_busy_done", 32'(if_msb.busy),      32'h0);
    check("lsb_out",      32'(if_lsb.par_out),   32'h4D);
    @(negedge clk);
    check("b2_valid_fall", 32'(if_msb.par_valid), 32'h0);

    // Overrun with consumer stalled
    par_ready = 1'b0;
    send_word(8'hB2);
    check("ovr_first_valid", 32'(if_msb.par_valid), 32'h1);
    check("ovr_none_yet",    32'(if_msb.overrun),   32'h0);
    send_word(8'h5A);
    check("ovr_pulse",       32'(if_msb.overrun),   32'h1);
    check("ovr_hold_out",    32'(if_msb.par_out),   32'hB2);
    @(negedge clk);
    check("ovr_one_cycle",   32'(if_msb.overrun),   32'h0);
    check("ovr_still_valid", 32'(if_msb.par_valid), 32'h1);
    pop_one();
    check("ovr_pop_fall",    32'(if_msb.par_valid), 32'h0);

    // Back-to-back words at full rate
    par_ready = 1'b1;
    pat = 16'hA53C;
    ovr_seen = 0;
    for (int i = 0; i < 16; i++) begin
      send_bit(pat[15-i]);
      check($sformatf("b2b_valid_%0d", i), 32'(if_msb.par_valid), 32'((i == 7) || (i == 15)));
      if (if_msb.overrun) ovr_seen++;
      if (i == 7)  check("b2b_out_a5", 32'(if_msb.par_out), 32'hA5);
      if (i == 15) check("b2b_out_3c", 32'(if_msb.par_out), 32'h3C);
    end
    check("b2b_no_overrun", 32'(ovr_seen), 32'h0);
    @(negedge clk);
    check("b2b_valid_fall", 32'(if_msb.par_valid), 32'h0);

    // Pop on the completion edge of the next word
    par_ready = 1'b0;
    send_word(8'hA5);
    w = 8'h3C;
    for (int i = 7; i >= 1; i--) send_bit(w[i]);
    check("swap_old_held", 32'(if_msb.par_out), 32'hA5);
    par_ready = 1'b1;
    send_bit(w[0]);
    par_ready = 1'b0;
    check("swap_valid",   32'(if_msb.par_valid), 32'h1);
    check("swap_out",     32'(if_msb.par_out),   32'h3C);
    check("swap_overrun", 32'(if_msb.overrun),   32'h0);
    pop_one();
    check("swap_drained", 32'(if_msb.par_valid), 32'h0);

    // clear discards a partial word but leaves the held word alone
    send_word(8'h5A);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    check("clr_busy_before", 32'(if_msb.busy), 32'h1);
    clear = 1'b1; ser_in = 1'b1; ser_valid = 1'b1;
    @(negedge clk);
    clear = 1'b0; ser_valid = 1'b0;
    check("clr_busy_after", 32'(if_msb.busy),      32'h0);
    check("clr_hold_valid", 32'(if_msb.par_valid), 32'h1);
    check("clr_hold_out",   32'(if_msb.par_out),   32'h5A);
    pop_one();
    send_word(8'hC3);
    check("clr_c3_out",   32'(if_msb.par_out),   32'hC3);
    check("clr_c3_valid", 32'(if_msb.par_valid), 32'h1);
    pop_one();

    // Asynchronous reset mid-word, then a word with irregular gaps
    send_word(8'h77);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    check("mid_busy", 32'(if_msb.busy), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_par_out",   32'(if_msb.par_out),   32'h0);
    check("arst_par_valid", 32'(if_msb.par_valid), 32'h0);
    check("arst_busy",      32'(if_msb.busy),      32'h0);
    check("arst_overrun",   32'(if_msb.overrun),   32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    gaps = '{0, 2, 1, 3, 0, 1, 2, 1};
    w = 8'h81;
    for (int i = 0; i < 8; i++) begin
      send_bit(w[7-i]);
      ser_in = ~w[7-i];
      repeat (gaps[i]) @(negedge clk);
      if (i == 3) check("gap_busy", 32'(if_msb.busy), 32'h1);
    end
    check("gap_out",   32'(if_msb.par_out),   32'h81);
    check("gap_valid", 32'(if_msb.par_valid), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
